// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: loadable instruction memory, PC and CPI pacer driving the core's ir.
// Optional halt-on-opcode-F behaviour is enabled by defining INSTR_FETCH_HALT_EN.
module instr_fetch #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int CPI    = 5
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              run,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_new,
  output logic              busy,
  output logic              halted
);

  localparam int PACE_W = $clog2(CPI);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef INSTR_FETCH_HALT_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  logic [31:0]       r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_fetch_ptr;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_ir_new;
  logic [PACE_W-1:0] r_pacer;
  logic [31:0]       w_fetch_word;

  assign w_fetch_word = r_mem[r_fetch_ptr];

  // Program memory is written only while idle and is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

`ifdef INSTR_FETCH_HALT_EN
  logic r_halt_pend;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_halt_pend <= 1'b0;
    end else if (r_state == S_FETCH && w_fetch_word[31:28] == 4'hF) begin
      r_halt_pend <= 1'b1;
    end
  end

  assign halted = (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  // The FETCH cycle doubles as the last cycle of the previous window, so ir changes exactly every CPI clocks.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state     <= S_IDLE;
      r_fetch_ptr <= '0;
      r_pc        <= '0;
      r_ir        <= 32'h0000_0000;
      r_ir_new    <= 1'b0;
      r_pacer     <= '0;
    end else begin
      r_ir_new <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state     <= S_FETCH;
            r_fetch_ptr <= '0;
          end
        end
        S_FETCH: begin
`ifdef INSTR_FETCH_HALT_EN
          if (r_halt_pend) begin
            r_state <= S_HALT;
          end else
`endif
          begin
            r_ir        <= w_fetch_word;
            r_pc        <= r_fetch_ptr;
            r_fetch_ptr <= r_fetch_ptr + ADDR_W'(1);
            r_ir_new    <= 1'b1;
            r_pacer     <= PACE_W'(1);
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_pacer <= r_pacer + PACE_W'(1);
          if (r_pacer == PACE_W'(CPI - 1)) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign ir     = r_ir;
  assign pc     = r_pc;
  assign ir_new = r_ir_new;
  assign busy   = (r_state == S_FETCH) || (r_state == S_HOLD);

endmodule
